pcie_egress_arbiter: RTL and testbench



---
 rtl/pcie_egress_arbiter_pkg.sv | 36 +++
 rtl/pcie_egress_arbiter_if.sv | 61 ++++++
 rtl/pcie_egress_arbiter_rr_select.sv | 37 +++
 rtl/pcie_egress_arbiter.sv | 142 ++++++++++++++
 tb/tb_pcie_egress_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_egress_arbiter_pkg.sv
// Shared types for the PCIe egress arbiter: FSM state encoding, TLP header
// field widths and the packed views used to steer header/FIFO data.
package pcie_egress_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_t;

  localparam int CMD_W       = 8;
  localparam int FLAGS_W     = 14;
  localparam int ADDR_W      = 32;
  localparam int RID_W       = 16;
  localparam int TAG_W       = 8;
  localparam int FIFO_SIZE_W = 24;
  localparam int FIFO_DATA_W = 32;

  // One requester's TLP header as latched at grant time.
  typedef struct packed {
    logic [CMD_W-1:0]   command;
    logic [FLAGS_W-1:0] flags;
    logic [ADDR_W-1:0]  address;
    logic [RID_W-1:0]   requester_id;
    logic [TAG_W-1:0]   tag;
  } tlp_hdr_t;

  // One requester's FIFO status/data as seen by the egress engine.
  typedef struct packed {
    logic                   rdy;
    logic [FIFO_SIZE_W-1:0] size;
    logic [FIFO_DATA_W-1:0] data;
  } fifo_view_t;

endpackage

// File: rtl/pcie_egress_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the egress arbiter.
// master = the arbiter itself, slave = the surrounding requesters + engine.
interface pcie_egress_arbiter_if
  import pcie_egress_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int REQ_IDW = 3
);

  // Requester side
  logic                           i_enable;
  logic [NUM_REQ-1:0]             i_req;
  logic [NUM_REQ*CMD_W-1:0]       i_req_command;
  logic [NUM_REQ*FLAGS_W-1:0]     i_req_flags;
  logic [NUM_REQ*ADDR_W-1:0]      i_req_address;
  logic [NUM_REQ*RID_W-1:0]       i_req_requester_id;
  logic [NUM_REQ*TAG_W-1:0]       i_req_tag;
  logic [NUM_REQ-1:0]             i_req_fifo_rdy;
  logic [NUM_REQ*FIFO_SIZE_W-1:0] i_req_fifo_size;
  logic [NUM_REQ*FIFO_DATA_W-1:0] i_req_fifo_data;
  logic [NUM_REQ-1:0]             o_req_fifo_act;
  logic [NUM_REQ-1:0]             o_req_fifo_stb;
  logic [NUM_REQ-1:0]             o_req_done;
  logic                           o_busy;
  logic [REQ_IDW-1:0]             o_grant_id;

  // Egress engine side
  logic                           o_egress_enable;
  logic                           i_egress_finished;
  logic [CMD_W-1:0]               o_egress_command;
  logic [FLAGS_W-1:0]             o_egress_flags;
  logic [ADDR_W-1:0]              o_egress_address;
  logic [RID_W-1:0]               o_egress_requester_id;
  logic [TAG_W-1:0]               o_egress_tag;
  logic                           o_egress_fifo_rdy;
  logic [FIFO_SIZE_W-1:0]         o_egress_fifo_size;
  logic [FIFO_DATA_W-1:0]         o_egress_fifo_data;
  logic                           i_egress_fifo_act;
  logic                           i_egress_fifo_stb;

  modport master (
    input  i_enable, i_req, i_req_command, i_req_flags, i_req_address,
           i_req_requester_id, i_req_tag, i_req_fifo_rdy, i_req_fifo_size,
           i_req_fifo_data, i_egress_finished, i_egress_fifo_act, i_egress_fifo_stb,
    output o_req_fifo_act, o_req_fifo_stb, o_req_done, o_busy, o_grant_id,
           o_egress_enable, o_egress_command, o_egress_flags, o_egress_address,
           o_egress_requester_id, o_egress_tag, o_egress_fifo_rdy,
           o_egress_fifo_size, o_egress_fifo_data
  );

  modport slave (
    output i_enable, i_req, i_req_command, i_req_flags, i_req_address,
           i_req_requester_id, i_req_tag, i_req_fifo_rdy, i_req_fifo_size,
           i_req_fifo_data, i_egress_finished, i_egress_fifo_act, i_egress_fifo_stb,
    input  o_req_fifo_act, o_req_fifo_stb, o_req_done, o_busy, o_grant_id,
           o_egress_enable, o_egress_command, o_egress_flags, o_egress_address,
           o_egress_requester_id, o_egress_tag, o_egress_fifo_rdy,
           o_egress_fifo_size, o_egress_fifo_data
  );

endinterface

// File: rtl/pcie_egress_arbiter_rr_select.sv
// pcie_rr_select: combinational round-robin winner finder. Searches the
// request vector from ptr upward, wrapping at NUM_REQ. With prio0 set,
// requester 0 wins outright whenever it is requesting.
module pcie_rr_select #(
  parameter int NUM_REQ = 3,
  parameter int REQ_IDW = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_IDW-1:0] ptr,
  input  logic               prio0,
  output logic               valid,
  output logic [REQ_IDW-1:0] idx
);

  int cand;

  // First requesting index at or after ptr, in circular order.
  always_comb begin
    // NOTE: every output gets a default up front so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    if (prio0 && req[0]) begin
      valid = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = int'(ptr) + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!valid && req[cand]) begin
          valid = 1'b1;
          idx   = REQ_IDW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// pcie_egress_arbiter: shares one PCIe egress TLP engine among NUM_REQ
// requesters. Round-robin grant, latched header, enable/finished handshake
// and FIFO steering to the granted requester.
// Optional build macro PCIE_EGRESS_ARB_CPL_PRIORITY_EN: requester 0
// (completions) always wins arbitration when it is requesting.
module pcie_egress_arbiter
  import pcie_egress_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int REQ_IDW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pcie_egress_arbiter_if.master bus
);

  // Per-slot views sized to the full index space so any grant index is in range.
  localparam int SLOTS = 1 << REQ_IDW;

  tlp_hdr_t   hdr_slot  [SLOTS];
  fifo_view_t fifo_slot [SLOTS];

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < NUM_REQ) begin : g_used
      assign hdr_slot[k] = {bus.i_req_command[k*CMD_W +: CMD_W],
                            bus.i_req_flags[k*FLAGS_W +: FLAGS_W],
                            bus.i_req_address[k*ADDR_W +: ADDR_W],
                            bus.i_req_requester_id[k*RID_W +: RID_W],
                            bus.i_req_tag[k*TAG_W +: TAG_W]};
      assign fifo_slot[k] = {bus.i_req_fifo_rdy[k],
                             bus.i_req_fifo_size[k*FIFO_SIZE_W +: FIFO_SIZE_W],
                             bus.i_req_fifo_data[k*FIFO_DATA_W +: FIFO_DATA_W]};
    end else begin : g_unused
      assign hdr_slot[k]  = '0;
      assign fifo_slot[k] = '0;
    end
  end

  arb_state_t         state;
  tlp_hdr_t           hdr_q;
  logic [REQ_IDW-1:0] grant_q;
  logic [REQ_IDW-1:0] rr_ptr;
  logic               enable_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] grant_oh;
  logic               win_valid;
  logic [REQ_IDW-1:0] win_idx;
  logic               prio0;
  fifo_view_t         fifo_sel;

`ifdef PCIE_EGRESS_ARB_CPL_PRIORITY_EN
  assign prio0 = 1'b1;
`else
  assign prio0 = 1'b0;
`endif

  pcie_rr_select #(
    .NUM_REQ (NUM_REQ),
    .REQ_IDW (REQ_IDW)
  ) u_rr_select (
    .req   (bus.i_req),
    .ptr   (rr_ptr),
    .prio0 (prio0),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // One-hot decode of the latched grant index.
  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_oh[k] = (grant_q == REQ_IDW'(k));
    end
  end

  // Arbitration FSM with registered handshake outputs and latched header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr_q    <= '0;
      grant_q  <= '0;
      rr_ptr   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.i_enable && win_valid) begin
            hdr_q   <= hdr_slot[win_idx];
            grant_q <= win_idx;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          enable_q <= 1'b1;
          busy_q   <= 1'b1;
          state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.i_egress_finished) begin
            done_q   <= grant_oh;
            enable_q <= 1'b0;
            rr_ptr   <= (grant_q == REQ_IDW'(NUM_REQ - 1)) ? '0 : grant_q + REQ_IDW'(1);
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!bus.i_egress_finished) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_egress_enable       = enable_q;
  assign bus.o_busy                = busy_q;
  assign bus.o_req_done            = done_q;
  assign bus.o_grant_id            = grant_q;
  assign bus.o_egress_command      = hdr_q.command;
  assign bus.o_egress_flags        = hdr_q.flags;
  assign bus.o_egress_address      = hdr_q.address;
  assign bus.o_egress_requester_id = hdr_q.requester_id;
  assign bus.o_egress_tag          = hdr_q.tag;

  // FIFO status/data follow the latched grant, blanked while idle.
  assign fifo_sel               = fifo_slot[grant_q];
  assign bus.o_egress_fifo_rdy  = (state != ST_IDLE) && fifo_sel.rdy;
  assign bus.o_egress_fifo_size = (state != ST_IDLE) ? fifo_sel.size : '0;
  assign bus.o_egress_fifo_data = (state != ST_IDLE) ? fifo_sel.data : '0;

  // Engine FIFO controls go only to the granted requester.
  assign bus.o_req_fifo_act = grant_oh & {NUM_REQ{bus.i_egress_fifo_act}};
  assign bus.o_req_fifo_stb = grant_oh & {NUM_REQ{bus.i_egress_fifo_stb}};

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// Directed testbench for pcie_egress_arbiter (NUM_REQ=3, REQ_IDW=3).
// Expected priority-test grant depends on PCIE_EGRESS_ARB_CPL_PRIORITY_EN.
module tb_pcie_egress_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  pcie_egress_arbiter_if #(.NUM_REQ(3), .REQ_IDW(3)) bus ();

  pcie_egress_arbiter #(.NUM_REQ(3), .REQ_IDW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_enable           = 1'b1;
    bus.i_req              = '0;
    bus.i_req_command      = {8'h33, 8'h22, 8'h11};
    bus.i_req_flags        = {14'h0333, 14'h0222, 14'h0111};
    bus.i_req_address      = {32'h3000_0300, 32'h2000_0200, 32'h1000_0100};
    bus.i_req_requester_id = {16'h0300, 16'h0200, 16'h0100};
    bus.i_req_tag          = {8'h03, 8'h02, 8'h01};
    bus.i_req_fifo_rdy     = '0;
    bus.i_req_fifo_size    = '0;
    bus.i_req_fifo_data    = '0;
    bus.i_egress_finished  = 1'b0;
    bus.i_egress_fifo_act  = 1'b0;
    bus.i_egress_fifo_stb  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait for a grant, check its index, finish it and check done/busy.
  task automatic run_xfer(input logic [2:0] exp_grant, input bit drop_req);
    bit seen;
    logic [2:0] exp_done;
    seen = 1'b0;
    exp_done = 3'b001 << exp_grant;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (bus.o_egress_enable === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL xfer_enable_timeout: enable not seen, expected grant %0d", exp_grant);
    end else begin
      n_cmp++;
      if (bus.o_grant_id !== exp_grant) begin
        n_err++;
        $display("FAIL xfer_grant: got %0d expected %0d", bus.o_grant_id, exp_grant);
      end
      bus.i_egress_finished = 1'b1;
      tick();
      n_cmp++;
      if (bus.o_req_done !== exp_done) begin
        n_err++;
        $display("FAIL xfer_done: got %b expected %b", bus.o_req_done, exp_done);
      end
      bus.i_egress_finished = 1'b0;
      if (drop_req) bus.i_req = '0;
      tick();
      n_cmp++;
      if (bus.o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL xfer_busy_clear: got %b expected 0", bus.o_busy);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.o_egress_enable, bus.o_busy, bus.o_req_done, bus.o_grant_id} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b busy=%b done=%b grant=%0d expected all 0",
               bus.o_egress_enable, bus.o_busy, bus.o_req_done, bus.o_grant_id);
    end
    n_cmp++;
    if ({bus.o_egress_command, bus.o_egress_address, bus.o_egress_tag} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_header: cmd=%h addr=%h tag=%h expected 0",
               bus.o_egress_command, bus.o_egress_address, bus.o_egress_tag);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.i_req_command[15:8]  = 8'h40;
    bus.i_req_address[63:32] = 32'h1000_0000;
    bus.i_req = 3'b010;
    tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b0) begin
      n_err++;
      $display("FAIL single_enable_early: got %b expected 0", bus.o_egress_enable);
    end
    tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b1 || bus.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_enable: en=%b busy=%b expected 1/1", bus.o_egress_enable, bus.o_busy);
    end
    n_cmp++;
    if (bus.o_grant_id !== 3'd1 || bus.o_egress_command !== 8'h40 ||
        bus.o_egress_address !== 32'h1000_0000 || bus.o_egress_tag !== 8'h02 ||
        bus.o_egress_requester_id !== 16'h0200 || bus.o_egress_flags !== 14'h0222) begin
      n_err++;
      $display("FAIL single_header: grant=%0d cmd=%h addr=%h tag=%h rid=%h flags=%h expected 1/40/10000000/02/0200/0222",
               bus.o_grant_id, bus.o_egress_command, bus.o_egress_address, bus.o_egress_tag,
               bus.o_egress_requester_id, bus.o_egress_flags);
    end
    // Header must ignore input changes after the latch.
    bus.i_req_command[15:8] = 8'h99;
    repeat (10) tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b1 || bus.o_egress_command !== 8'h40 || bus.o_req_done !== 3'b000) begin
      n_err++;
      $display("FAIL single_hold: en=%b cmd=%h done=%b expected 1/40/000",
               bus.o_egress_enable, bus.o_egress_command, bus.o_req_done);
    end
    bus.i_egress_finished = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_req_done !== 3'b010 || bus.o_egress_enable !== 1'b0 || bus.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: done=%b en=%b busy=%b expected 010/0/1",
               bus.o_req_done, bus.o_egress_enable, bus.o_busy);
    end
    bus.i_req = '0;
    tick();
    n_cmp++;
    if (bus.o_req_done !== 3'b000 || bus.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_release_hold: done=%b busy=%b expected 000/1", bus.o_req_done, bus.o_busy);
    end
    bus.i_egress_finished = 1'b0;
    tick();
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_clear: got %b expected 0", bus.o_busy);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] order [6];
    order = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    do_reset();
    bus.i_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      run_xfer(order[t], t == 5);
    end
  endtask

  task automatic test_fifo_steer();
    do_reset();
    bus.i_req_fifo_size = {24'd4, 24'd9, 24'd7};
    bus.i_req_fifo_rdy  = 3'b100;
    bus.i_req_fifo_data = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    n_cmp++;
    if (bus.o_egress_fifo_size !== 24'd0 || bus.o_egress_fifo_rdy !== 1'b0 || bus.o_egress_fifo_data !== 32'h0) begin
      n_err++;
      $display("FAIL steer_idle_gate: size=%0d rdy=%b data=%h expected 0/0/0",
               bus.o_egress_fifo_size, bus.o_egress_fifo_rdy, bus.o_egress_fifo_data);
    end
    bus.i_req = 3'b100;
    tick();
    tick();
    n_cmp++;
    if (bus.o_egress_fifo_size !== 24'd4 || bus.o_egress_fifo_rdy !== 1'b1 ||
        bus.o_egress_fifo_data !== 32'hDEAD_BEEF || bus.o_grant_id !== 3'd2) begin
      n_err++;
      $display("FAIL steer_mux: size=%0d rdy=%b data=%h grant=%0d expected 4/1/deadbeef/2",
               bus.o_egress_fifo_size, bus.o_egress_fifo_rdy, bus.o_egress_fifo_data, bus.o_grant_id);
    end
    bus.i_egress_fifo_act = 1'b1;
    bus.i_egress_fifo_stb = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_req_fifo_act !== 3'b100 || bus.o_req_fifo_stb !== 3'b100) begin
      n_err++;
      $display("FAIL steer_stb_high: act=%b stb=%b expected 100/100", bus.o_req_fifo_act, bus.o_req_fifo_stb);
    end
    bus.i_egress_fifo_stb = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_req_fifo_act !== 3'b100 || bus.o_req_fifo_stb !== 3'b000) begin
      n_err++;
      $display("FAIL steer_stb_low: act=%b stb=%b expected 100/000", bus.o_req_fifo_act, bus.o_req_fifo_stb);
    end
    bus.i_egress_fifo_act = 1'b0;
    bus.i_egress_finished = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_req_done !== 3'b100) begin
      n_err++;
      $display("FAIL steer_done: got %b expected 100", bus.o_req_done);
    end
    bus.i_req = '0;
    bus.i_egress_finished = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    bus.i_enable = 1'b0;
    bus.i_req = 3'b001;
    repeat (5) tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL enable_blocks: en=%b busy=%b expected 0/0", bus.o_egress_enable, bus.o_busy);
    end
    bus.i_enable = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b1) begin
      n_err++;
      $display("FAIL enable_grant: got %b expected 1", bus.o_egress_enable);
    end
    bus.i_enable = 1'b0;
    tick();
    bus.i_egress_finished = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_req_done !== 3'b001) begin
      n_err++;
      $display("FAIL enable_drop_done: got %b expected 001", bus.o_req_done);
    end
    bus.i_egress_finished = 1'b0;
    tick();
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL enable_drop_busy: got %b expected 0", bus.o_busy);
    end
    // Still requesting with enable low: no new grant.
    repeat (4) tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL enable_no_regrant: en=%b busy=%b expected 0/0", bus.o_egress_enable, bus.o_busy);
    end
    bus.i_req = '0;
    bus.i_enable = 1'b1;
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.i_req = 3'b010;
    #3;
    bus.i_req = 3'b000;
    repeat (3) tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL req_drop_no_grant: en=%b busy=%b expected 0/0", bus.o_egress_enable, bus.o_busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_req = 3'b100;
    repeat (3) tick();
    n_cmp++;
    if (bus.o_egress_enable !== 1'b1 || bus.o_grant_id !== 3'd2) begin
      n_err++;
      $display("FAIL areset_setup: en=%b grant=%0d expected 1/2", bus.o_egress_enable, bus.o_grant_id);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_egress_enable !== 1'b0 || bus.o_grant_id !== 3'd0 || bus.o_busy !== 1'b0 ||
        bus.o_egress_command !== 8'h00) begin
      n_err++;
      $display("FAIL areset_immediate: en=%b grant=%0d busy=%b cmd=%h expected 0/0/0/00",
               bus.o_egress_enable, bus.o_grant_id, bus.o_busy, bus.o_egress_command);
    end
    bus.i_egress_finished = 1'b1;
    tick();
    bus.i_req = '0;
    bus.i_egress_finished = 1'b0;
    rst = 1'b0;
    n_cmp++;
    if (bus.o_req_done !== 3'b000) begin
      n_err++;
      $display("FAIL areset_no_done: got %b expected 000", bus.o_req_done);
    end
    tick();
    n_cmp++;
    if (bus.o_req_done !== 3'b000 || bus.o_egress_enable !== 1'b0) begin
      n_err++;
      $display("FAIL areset_after: done=%b en=%b expected 000/0", bus.o_req_done, bus.o_egress_enable);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_first;
`ifdef PCIE_EGRESS_ARB_CPL_PRIORITY_EN
    exp_first = 3'd0;
`else
    exp_first = 3'd1;
`endif
    do_reset();
    bus.i_req = 3'b001;
    run_xfer(3'd0, 1'b1);
    bus.i_req = 3'b011;
    run_xfer(exp_first, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_fifo_steer();
    test_enable();
    test_req_drop();
    test_async_reset();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
